// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - byte requester bundle between transmit sources and the TX scheduler
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte arbiter feeding one 8N1 UART transmitter gated by cts_n
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 434
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_sched_if.slave             req,
    input  logic                       cts_n,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_d;
    logic             cts_meta, cts_s;
    logic [PTR_W-1:0] rr_ptr, winner, cand;
    logic             found, grant, bit_end;
    logic [CNT_W-1:0] bit_cnt, cnt_d;
    logic [2:0]       bit_idx, idx_d;
    logic [7:0]       shreg;
    logic             tx_d;

    // Both flops start at "peer busy" so nothing is granted until cts_n has been seen low twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta <= 1'b1;
            cts_s    <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_s    <= cts_meta;
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
            if (!found && req.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant         = (state == IDLE) && !cts_s && found;
        req.req_ready = '0;
        req.req_ready[winner] = grant;
    end

    always_comb begin
        state_d    = state;
        cnt_d      = bit_cnt;
        idx_d      = bit_idx;
        frame_done = 1'b0;
        bit_end    = (bit_cnt == CNT_MAX);
        case (state)
            IDLE: begin
                if (grant) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 idx_d   = bit_idx + 3'd1;
                end else begin
                    cnt_d = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (bit_end) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    frame_done = 1'b1;
                end else begin
                    cnt_d = bit_cnt + CNT_W'(1);
                end
            end
        endcase
        // tx is registered from the level the next state will drive.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= cnt_d;
            bit_idx <= idx_d;
            tx      <= tx_d;
            if (grant) begin
                shreg    <= req.req_data[{winner, 3'b000} +: 8];
                grant_id <= winner;
                rr_ptr   <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed vector bench for uart_tx_sched at NUM_REQ=4, CLK_DIV=4
module tb_uart_tx_sched;
    localparam int NUM_REQ = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       cts_n;
    logic       tx, busy, frame_done;
    logic [1:0] grant_id;
    int         n_checks = 0;
    int         n_err    = 0;

    uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) rif ();

    uart_tx_sched #(.NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (rif),
        .cts_n      (cts_n),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid_before;
        logic [31:0] data;
        logic [3:0]  valid_after;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [7:0]  exp_byte;
        int          exp_wait;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input logic [3:0] exp_ready, input int exp_wait, input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        while (rif.req_ready == 4'b0000 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready"}, 64'(rif.req_ready), 64'(exp_ready));
        if (exp_wait >= 0) check({name, " latency"}, 64'(waited), 64'(exp_wait));
    endtask

    // Samples one whole frame starting with the cycle after the handshake edge.
    task automatic check_frame(input logic [1:0] exp_id, input logic [7:0] exp_byte,
                               input int cts_at, input string name);
        logic [39:0] obs_tx, obs_busy, obs_done, exp_tx;
        logic [3:0]  obs_rdy;
        logic [9:0]  bits;
        bits    = {1'b1, exp_byte, 1'b0};
        obs_rdy = '0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            obs_tx[c]   = tx;
            obs_busy[c] = busy;
            obs_done[c] = frame_done;
            exp_tx[c]   = bits[c / CLK_DIV];
            obs_rdy     = obs_rdy | rif.req_ready;
            if (c == cts_at) cts_n = 1'b1;
        end
        check({name, " tx bits"},    64'(obs_tx),   64'(exp_tx));
        check({name, " busy"},       64'(obs_busy), 64'(40'hFF_FFFF_FFFF));
        check({name, " frame_done"}, 64'(obs_done), 64'(40'h80_0000_0000));
        check({name, " no ready"},   64'(obs_rdy),  64'(0));
        check({name, " grant_id"},   64'(grant_id), 64'(exp_id));
    endtask

    initial begin
        logic [3:0] acc_rdy;
        logic       acc_tx;
        int         n;

        vecs[0] = '{4'hF, 32'h13121110, 4'hF, 4'b0001, 2'd0, 8'h10, 1};
        vecs[1] = '{4'hF, 32'h13121110, 4'hF, 4'b0010, 2'd1, 8'h11, 0};
        vecs[2] = '{4'hF, 32'h13121110, 4'hF, 4'b0100, 2'd2, 8'h12, 0};
        vecs[3] = '{4'hF, 32'h13121110, 4'hF, 4'b1000, 2'd3, 8'h13, 0};
        vecs[4] = '{4'hF, 32'h13121110, 4'h0, 4'b0001, 2'd0, 8'h10, 0};
        vecs[5] = '{4'b0100, 32'h13121110, 4'h0,    4'b0100, 2'd2, 8'h12, 0};
        vecs[6] = '{4'b0011, 32'h13121110, 4'b0010, 4'b0001, 2'd0, 8'h10, 0};
        vecs[7] = '{4'b0010, 32'h13121110, 4'h0,    4'b0010, 2'd1, 8'h11, 0};
        vecs[8] = '{4'b1001, 32'h5E121181, 4'b1001, 4'b1000, 2'd3, 8'h5E, 0};
        vecs[9] = '{4'b1001, 32'h5E121181, 4'h0,    4'b0001, 2'd0, 8'h81, 0};

        rst           = 1'b1;
        cts_n         = 1'b0;
        rif.req_valid = 4'b0001;
        rif.req_data  = 32'h000000A5;
        repeat (3) @(negedge clk);
        check("reset tx",         64'(tx),            64'(1));
        check("reset busy",       64'(busy),          64'(0));
        check("reset grant_id",   64'(grant_id),      64'(0));
        check("reset frame_done", 64'(frame_done),    64'(0));
        check("reset ready",      64'(rif.req_ready), 64'(0));

        // Single request straight out of reset: grant lands in the third cycle.
        rst = 1'b0;
        #1;
        check("release ready", 64'(rif.req_ready), 64'(0));
        wait_grant(4'b0001, 1, "single");
        @(posedge clk); #1;
        rif.req_valid = 4'b0000;
        check_frame(2'd0, 8'hA5, -1, "single");
        @(negedge clk);
        check("single idle busy", 64'(busy), 64'(0));
        check("single idle tx",   64'(tx),   64'(1));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rif.req_valid = vecs[i].valid_before;
            rif.req_data  = vecs[i].data;
            wait_grant(vecs[i].exp_ready, vecs[i].exp_wait, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            rif.req_valid = vecs[i].valid_after;
            check_frame(vecs[i].exp_id, vecs[i].exp_byte, -1, $sformatf("vec%0d", i));
        end

        // Flow control: peer busy holds everything off.
        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        rif.req_valid = 4'b0100;
        rif.req_data  = 32'h00C30000;
        acc_rdy = '0;
        acc_tx  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc_rdy = acc_rdy | rif.req_ready;
            acc_tx  = acc_tx & tx;
        end
        check("cts hold ready", 64'(acc_rdy), 64'(0));
        check("cts hold tx",    64'(acc_tx),  64'(1));
        cts_n = 1'b0;
        n = 0;
        while (rif.req_ready == 4'b0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("cts release latency", 64'((n >= 2) && (n <= 3)), 64'(1));
        check("cts release ready",   64'(rif.req_ready),         64'(4'b0100));
        @(posedge clk); #1;
        rif.req_valid = 4'b0000;
        check_frame(2'd2, 8'hC3, -1, "cts frame");

        // Peer goes busy during DATA bit 3; frame must finish untouched.
        rif.req_valid = 4'b0010;
        rif.req_data  = 32'h00004D00;
        wait_grant(4'b0010, 0, "midcts");
        @(posedge clk); #1;
        rif.req_data = 32'h0000B200;
        check_frame(2'd1, 8'h4D, 17, "midcts");
        acc_rdy = '0;
        acc_tx  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc_rdy = acc_rdy | rif.req_ready;
            acc_tx  = acc_tx & tx;
        end
        check("midcts withheld ready", 64'(acc_rdy), 64'(0));
        check("midcts withheld tx",    64'(acc_tx),  64'(1));
        cts_n = 1'b0;
        wait_grant(4'b0010, 1, "midcts resume");
        @(posedge clk); #1;
        rif.req_valid = 4'b0000;
        check_frame(2'd1, 8'hB2, -1, "midcts resume");

        // Reset during DATA bit 5 of requester 2's frame.
        rif.req_valid = 4'b0100;
        rif.req_data  = 32'h00C30000;
        wait_grant(4'b0100, 0, "midrst");
        @(posedge clk); #1;
        rif.req_valid = 4'b0000;
        for (int c = 0; c < 26; c++) @(negedge clk);
        check("midrst pre busy",     64'(busy),     64'(1));
        check("midrst pre grant_id", 64'(grant_id), 64'(2));
        check("midrst pre tx",       64'(tx),       64'(0));
        rst = 1'b1;
        #1;
        check("midrst tx",         64'(tx),         64'(1));
        check("midrst busy",       64'(busy),       64'(0));
        check("midrst grant_id",   64'(grant_id),   64'(0));
        check("midrst frame_done", 64'(frame_done), 64'(0));
        @(negedge clk);
        rst           = 1'b0;
        rif.req_valid = 4'b1010;
        rif.req_data  = 32'hAA006B00;
        wait_grant(4'b0010, 1, "postrst");
        @(posedge clk); #1;
        rif.req_valid = 4'b0000;
        check_frame(2'd1, 8'h6B, -1, "postrst");
        @(negedge clk);
        check("final idle busy", 64'(busy), 64'(0));
        check("final idle tx",   64'(tx),   64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the shared UART serial line. It arbitrates round-robin among NUM_REQ byte requesters and serialises the winning byte as one 8N1 frame on `tx`. Frame starts are gated by the peer's `cts_n` flow-control input. It sits between the APB-side transmit sources and the UART pin, and owns all bit timing for the TX direction.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200); minimum 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NUM_REQ  requester i holds a byte for transmission.
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe; the byte of requester i is consumed on the clock edge where req_valid[i] and req_ready[i] are both 1.
- cts_n  in  1  peer flow control, asynchronous: 0 = peer ready, 1 = peer busy.
- tx  out  1  serial output; idles high.
- busy  out  1  a frame is in progress (START, DATA or STOP state).
- grant_id  out  $clog2(NUM_REQ)  index of the requester of the current or last frame.
- frame_done  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- `cts_n` passes through a 2-flop synchroniser to give `cts_s`. Both flops reset to 1 (peer busy).
- States:
  - **IDLE**: tx=1. If cts_s=0 and any req_valid is set, the winner is the first valid index at or after `rr_ptr`, scanning upward and wrapping.
    - req_ready[winner]=1 combinationally in this cycle.
    - At the clock edge: latch req_data[winner] into the shift register, set grant_id to the winner, set rr_ptr to (winner+1) mod NUM_REQ, and go to START.
    - Otherwise stay in IDLE with req_ready all 0.
  - **START**: tx=0 for CLK_DIV cycles, then go to DATA.
  - **DATA**: 8 bits, LSB first, CLK_DIV cycles each. A 3-bit index counts bits; after bit 7 go to STOP.
  - **STOP**: tx=1 for CLK_DIV cycles. frame_done=1 in the final cycle, then go to IDLE.
- Bit timer: counts 0..CLK_DIV-1, width $clog2(CLK_DIV). It clears on every state change and wraps at CLK_DIV-1 to advance.
- req_ready is 0 in every state other than IDLE, and 0 whenever cts_s=1.
- cts_s is sampled only in IDLE. A change of cts_n mid-frame never aborts or stretches the frame in progress.
- A requester that drops req_valid before it is granted loses nothing. No byte is dequeued without a req_ready handshake.
- tx is driven from a register, so no combinational path exists from inputs to tx.

## Timing
- Reset values: tx=1, busy=0, grant_id=0, frame_done=0, rr_ptr=0, state=IDLE. req_ready=0 because cts_s=1 out of reset.
- After reset release with cts_n held 0, the earliest grant is in the 3rd clock cycle (synchroniser latency).
- Grant cycle N: tx falls at the edge that ends cycle N.
- Frame timing:
  - 10*CLK_DIV cycles from the tx falling edge to the return to IDLE.
  - busy=1 for exactly those cycles.
- Back-to-back: at least one IDLE cycle separates frames, so the start-to-start period is 10*CLK_DIV+1 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle, in rotating priority.
- Reset asserted mid-frame:
  - tx goes to 1 immediately (asynchronously) and the state returns to IDLE.
  - The accepted byte is discarded.
  - rr_ptr returns to 0.

## Test plan
- Single request: CLK_DIV=4, req_valid=4'b0001, req_data[7:0]=8'hA5, cts_n=0 -> one req_ready[0] pulse. tx carries 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit. frame_done pulses at cycle 40 of the frame; grant_id=0.
- Round robin: all four requesters valid continuously with bytes 8'h10..8'h13 -> frames go out in order 0,1,2,3,0. Start-to-start period is 41 cycles at CLK_DIV=4.
- Flow control: cts_n=1 with req_valid=4'b0100 -> tx stays 1 and req_ready stays 0 indefinitely. Set cts_n=0 -> req_ready[2] asserts 2-3 cycles later.
- Mid-frame CTS: raise cts_n during DATA bit 3 -> the frame completes with all 10 bits. The next grant is withheld until cts_n returns to 0.
- Reset mid-frame: assert rst during DATA bit 5 -> tx=1 in the same cycle, busy=0, and grant_id=0. After release, a new request with cts_n=0 produces a clean, complete frame.
- Wrap/priority: rr_ptr=3 after a grant to requester 2, with req_valid=4'b0011 -> requester 0 is granted, then requester 1.
